// File: rtl/sa2_pkg.sv
// Shared types and sizes for the 2x2 systolic-array controller.
// Pulled in by every sa2_* file via import sa2_pkg::*.
package sa2_pkg;
  localparam int DW  = 8;
  localparam int N_A = 16;
  localparam int N_B = 9;
  localparam int N_C = 4;

  localparam int A_W = N_A * DW;
  localparam int B_W = N_B * DW;
  localparam int C_W = N_C * DW;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    RUN    = 3'd3,
    OUT    = 3'd4
  } sa2_state_t;
endpackage

// File: rtl/sa2_if.sv
// Host-side bundle of sa2_ctrl: start, operand stream, result stream, status.
// master = host driving the controller, slave = the controller itself.
interface sa2_if;
  import sa2_pkg::*;

  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          err;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, err
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, err
  );
endinterface

// File: rtl/sa2_obuf.sv
// Result buffer and byte serializer: captures {c22,c21,c12,c11} on load and
// streams c11..c22 over valid/ready, flagging last on c22.
module sa2_obuf
  import sa2_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [C_W-1:0] c_in,
  output logic           valid,
  input  logic           ready,
  output logic [DW-1:0]  data,
  output logic           last,
  output logic           done
);
  logic [C_W-1:0] buf_reg;
  logic [1:0]     idx_reg;
  logic           valid_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_reg   <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      buf_reg   <= c_in;
      idx_reg   <= '0;
      valid_reg <= 1'b1;
    end else if (valid_reg && ready) begin
      if (idx_reg == 2'(N_C - 1)) begin
        valid_reg <= 1'b0;
        idx_reg   <= '0;
      end else begin
        idx_reg <= idx_reg + 2'd1;
      end
    end
  end

  // Data is a mux of registered state, so it cannot move while stalled.
  assign valid = valid_reg;
  assign data  = buf_reg[idx_reg*DW +: DW];
  assign last  = valid_reg && (idx_reg == 2'(N_C - 1));
  assign done  = valid_reg && ready && last;
endmodule

// File: rtl/sa2_ctrl.sv
// Controller for a 2x2 systolic array: loads A (16 B) and B (9 B) banks,
// runs the array, serializes results. Optional RUN watchdog: SA2_TIMEOUT_EN.
module sa2_ctrl
  import sa2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic           clk,
  input  logic           rst,
  sa2_if.slave           host,
  output logic [A_W-1:0] a_flat,
  output logic [B_W-1:0] b_flat,
  output logic           active_sa2,
  input  logic           done_sa2,
  input  logic [C_W-1:0] c_flat
);
  sa2_state_t    state_reg;
  logic [3:0]    ld_idx_reg;
  logic          in_ready_reg;
  logic          active_reg;
  logic          busy_reg;
  logic          obuf_done;
  logic [DW-1:0] a_bank_reg [N_A];
  logic [DW-1:0] b_bank_reg [N_B];

  wire beat    = host.in_valid && in_ready_reg;
  wire capture = (state_reg == RUN) && done_sa2;

`ifdef SA2_TIMEOUT_EN
  localparam int RCW = $clog2(TIMEOUT_CYC) + 1;
  logic [RCW-1:0] run_cnt_reg;
  logic           err_reg;
  assign host.err = err_reg;
`else
  assign host.err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      ld_idx_reg   <= '0;
      in_ready_reg <= 1'b0;
      active_reg   <= 1'b0;
      busy_reg     <= 1'b0;
`ifdef SA2_TIMEOUT_EN
      run_cnt_reg  <= '0;
      err_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: if (host.start) begin
          state_reg    <= LOAD_A;
          ld_idx_reg   <= '0;
          in_ready_reg <= 1'b1;
          busy_reg     <= 1'b1;
`ifdef SA2_TIMEOUT_EN
          err_reg      <= 1'b0;
`endif
        end
        LOAD_A: if (beat) begin
          if (ld_idx_reg == 4'(N_A - 1)) begin
            state_reg  <= LOAD_B;
            ld_idx_reg <= '0;
          end else begin
            ld_idx_reg <= ld_idx_reg + 4'd1;
          end
        end
        LOAD_B: if (beat) begin
          if (ld_idx_reg == 4'(N_B - 1)) begin
            state_reg    <= RUN;
            ld_idx_reg   <= '0;
            in_ready_reg <= 1'b0;
            active_reg   <= 1'b1;
`ifdef SA2_TIMEOUT_EN
            run_cnt_reg  <= '0;
`endif
          end else begin
            ld_idx_reg <= ld_idx_reg + 4'd1;
          end
        end
        RUN: begin
          // A done arriving on the final watchdog cycle still counts as success.
          if (done_sa2) begin
            state_reg  <= OUT;
            active_reg <= 1'b0;
          end
`ifdef SA2_TIMEOUT_EN
          else if (run_cnt_reg == RCW'(TIMEOUT_CYC - 1)) begin
            state_reg  <= IDLE;
            active_reg <= 1'b0;
            busy_reg   <= 1'b0;
            err_reg    <= 1'b1;
          end else begin
            run_cnt_reg <= run_cnt_reg + 1'b1;
          end
`endif
        end
        OUT: if (obuf_done) begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg    <= IDLE;
          in_ready_reg <= 1'b0;
          active_reg   <= 1'b0;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  // Operand banks: one byte register per slot, written only by its own beat.
  genvar gi;
  generate
    for (gi = 0; gi < N_A; gi++) begin : g_a_bank
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          a_bank_reg[gi] <= '0;
        else if (state_reg == LOAD_A && beat && ld_idx_reg == 4'(gi))
          a_bank_reg[gi] <= host.in_data;
      end
      assign a_flat[gi*DW +: DW] = a_bank_reg[gi];
    end
    for (gi = 0; gi < N_B; gi++) begin : g_b_bank
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          b_bank_reg[gi] <= '0;
        else if (state_reg == LOAD_B && beat && ld_idx_reg == 4'(gi))
          b_bank_reg[gi] <= host.in_data;
      end
      assign b_flat[gi*DW +: DW] = b_bank_reg[gi];
    end
  endgenerate

  assign host.in_ready = in_ready_reg;
  assign host.busy     = busy_reg;
  assign active_sa2    = active_reg;

  sa2_obuf u_obuf (
    .clk   (clk),
    .rst   (rst),
    .load  (capture),
    .c_in  (c_flat),
    .valid (host.out_valid),
    .ready (host.out_ready),
    .data  (host.out_data),
    .last  (host.out_last),
    .done  (obuf_done)
  );
endmodule

// File: tb/tb_sa2_ctrl.sv
// Directed self-checking bench for sa2_ctrl; watchdog steps run only when
// compiled with SA2_TIMEOUT_EN.
module tb_sa2_ctrl;
  import sa2_pkg::*;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [A_W-1:0] a_flat;
  logic [B_W-1:0] b_flat;
  logic           active_sa2;
  logic           done_sa2 = 1'b0;
  logic [C_W-1:0] c_flat = '0;
  int             total = 0;
  int             bad = 0;

  sa2_if host_if ();

  sa2_ctrl #(.TIMEOUT_CYC(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (host_if),
    .a_flat     (a_flat),
    .b_flat     (b_flat),
    .active_sa2 (active_sa2),
    .done_sa2   (done_sa2),
    .c_flat     (c_flat)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Loads 16 A bytes (a_base+k) then 9 B bytes (b_val); optional bubble before each beat.
  task automatic load_all(input logic [7:0] a_base, input logic [7:0] b_val, input bit bubble);
    for (int k = 0; k < N_A + N_B; k++) begin
      if (bubble) begin
        host_if.in_valid = 1'b0;
        host_if.in_data  = 8'hFF;
        step();
      end
      host_if.in_valid = 1'b1;
      host_if.in_data  = (k < N_A) ? a_base + 8'(k) : b_val;
      step();
      $display("beat %0d data=%02h", k, host_if.in_data);
    end
    host_if.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    host_if.start = 1'b1;
    step();
    host_if.start = 1'b0;
  endtask

  logic [A_W-1:0] exp_a;
  logic [B_W-1:0] exp_b;

  initial begin
    host_if.start     = 1'b0;
    host_if.in_valid  = 1'b0;
    host_if.in_data   = '0;
    host_if.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_busy", host_if.busy, 1'b0);
    chk("rst_in_ready", host_if.in_ready, 1'b0);
    chk("rst_out_valid", host_if.out_valid, 1'b0);
    chk("rst_active", active_sa2, 1'b0);
    chk("rst_err", host_if.err, 1'b0);
    rst = 1'b1;
    step();

    // No start after release, plus stray done in IDLE: stays idle
    host_if.in_valid = 1'b1;
    done_sa2 = 1'b1;
    c_flat = 32'hDEADBEEF;
    step();
    done_sa2 = 1'b0;
    host_if.in_valid = 1'b0;
    step();
    chk("idle_hold_busy", host_if.busy, 1'b0);
    chk("idle_done_out_valid", host_if.out_valid, 1'b0);

    // Start -> in_ready one cycle later, then 7 beats and async reset
    pulse_start();
    chk("start_in_ready", host_if.in_ready, 1'b1);
    for (int k = 0; k < 7; k++) begin
      host_if.in_valid = 1'b1;
      host_if.in_data  = 8'h80 + 8'(k);
      step();
    end
    host_if.in_valid = 1'b0;
    chk("partial_a", a_flat[55:0], 56'h86858483828180);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_busy", host_if.busy, 1'b0);
    chk("midrst_in_ready", host_if.in_ready, 1'b0);
    chk("midrst_a_flat", a_flat, '0);
    #2;
    rst = 1'b1;
    step();

    // Nominal run with bubbles on every other cycle
    pulse_start();
    chk("start2_in_ready", host_if.in_ready, 1'b1);
    // Spurious start and done while loading
    host_if.start = 1'b1;
    done_sa2 = 1'b1;
    step();
    host_if.start = 1'b0;
    done_sa2 = 1'b0;
    chk("spur_in_ready", host_if.in_ready, 1'b1);
    chk("spur_out_valid", host_if.out_valid, 1'b0);
    chk("spur_busy", host_if.busy, 1'b1);
    load_all(8'd1, 8'd1, 1'b1);
    for (int k = 0; k < N_A; k++) exp_a[k*8 +: 8] = 8'(k + 1);
    for (int k = 0; k < N_B; k++) exp_b[k*8 +: 8] = 8'd1;
    chk("run_active", active_sa2, 1'b1);
    chk("run_in_ready", host_if.in_ready, 1'b0);
    chk("a_flat_nominal", a_flat, exp_a);
    chk("b_flat_nominal", b_flat, exp_b);
    // Stray in_valid during RUN must not touch the banks
    host_if.in_valid = 1'b1;
    host_if.in_data  = 8'h77;
    for (int k = 0; k < 3; k++) step();
    host_if.in_valid = 1'b0;
    chk("run_active_hold", active_sa2, 1'b1);
    step();
    c_flat = 32'h5A4E2A1E;
    done_sa2 = 1'b1;
    step();
    done_sa2 = 1'b0;
    c_flat = 32'h11223344;
    chk("out_valid_latency", host_if.out_valid, 1'b1);
    chk("out_active_low", active_sa2, 1'b0);
    chk("beat0_data", host_if.out_data, 8'h1E);
    chk("beat0_last", host_if.out_last, 1'b0);
    chk("b_flat_after_run", b_flat, exp_b);
    host_if.out_ready = 1'b1;
    step();
    $display("out beat data=1E accepted");
    host_if.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_data", host_if.out_data, 8'h2A);
      chk("stall_valid", host_if.out_valid, 1'b1);
    end
    host_if.out_ready = 1'b1;
    step();
    $display("out beat data=2A accepted");
    chk("beat2_data", host_if.out_data, 8'h4E);
    step();
    $display("out beat data=4E accepted");
    chk("beat3_data", host_if.out_data, 8'h5A);
    chk("beat3_last", host_if.out_last, 1'b1);
    step();
    $display("out beat data=5A accepted");
    host_if.out_ready = 1'b0;
    chk("end_out_valid", host_if.out_valid, 1'b0);
    chk("end_busy", host_if.busy, 1'b0);
    chk("a_flat_held", a_flat, exp_a);

`ifdef SA2_TIMEOUT_EN
    // Watchdog expiry
    pulse_start();
    load_all(8'h40, 8'h02, 1'b0);
    for (int k = 0; k < 63; k++) step();
    chk("to_active_63", active_sa2, 1'b1);
    chk("to_err_63", host_if.err, 1'b0);
    step();
    chk("to_err", host_if.err, 1'b1);
    chk("to_active", active_sa2, 1'b0);
    chk("to_busy", host_if.busy, 1'b0);
    step();
    chk("to_out_valid", host_if.out_valid, 1'b0);
    pulse_start();
    chk("to_err_cleared", host_if.err, 1'b0);
    // Done on the 64th RUN cycle wins over the watchdog
    load_all(8'h50, 8'h03, 1'b0);
    for (int k = 0; k < 63; k++) step();
    c_flat = 32'h04030201;
    done_sa2 = 1'b1;
    step();
    done_sa2 = 1'b0;
    chk("tie_out_valid", host_if.out_valid, 1'b1);
    chk("tie_err", host_if.err, 1'b0);
    chk("tie_data", host_if.out_data, 8'h01);
    host_if.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    host_if.out_ready = 1'b0;
    chk("tie_idle", host_if.busy, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
